clos_alloc: RTL
===============

# clos_alloc

Synchronous allocator that computes the switch configuration for the data Clos network (`dclos`). It sits beside `dclos`: input buffers request an output direction per virtual circuit; the block assigns a free centre module, which is also the output virtual circuit index. It drives `imcfg`, `scfg`, `ncfg`, `wcfg`, `ecfg` and `lcfg`, and holds each circuit until the requester releases it after EOF.

## Interface
- `MN`, 2, number of centre modules (CMs), equal to the number of output VCs per direction.
- `NN`, 2, number of VCs per input module (IM).
- `MW`, `$clog2(MN)` (min 1), width of the CM index.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low, one clock domain.
- `req`  in  [4:0][NN-1:0]  request level, indexed by input direction d (0=S, 1=W, 2=N, 3=E, 4=L) and VC v.
- `rdir`  in  [4:0][NN-1:0][2:0]  target output direction, same encoding as d.
- `rel`  in  [4:0][NN-1:0]  one-cycle release pulse.
- `gnt`  out  [4:0][NN-1:0]  level; high while the circuit is allocated.
- `gcm`  out  [4:0][NN-1:0][MW-1:0]  allocated CM, which is also the output VC; valid while `gnt` is high.
- `err`  out  1  one-cycle pulse on an illegal request.
- `imcfg`  out  [4:0][MN-1:0][NN-1:0]  IM configuration.
- `scfg`, `ncfg`  out  [MN-1:0][1:0]  CM configuration for the S and N outputs.
- `wcfg`, `ecfg`, `lcfg`  out  [MN-1:0][3:0]  CM configuration for the W, E and L outputs.

## Operation
- **XY turn rules.** Sources allowed for each output, with cfg bit order from bit 0:
  - S: N, L
  - N: S, L
  - W: S, N, E, L
  - E: S, W, N, L
  - L: S, W, N, E
  - Any other (d, rdir) pair, including U-turns and rdir > 4, is illegal.
- **Resource state.** Registers `imbusy[d][m]` and `ombusy[o][m]`.
- **Allocatable.** (d,v) is allocatable when all hold:
  - `req` is high, `gnt` is low and the turn is legal;
  - some m has `!imbusy[d][m] && !ombusy[rdir][m]`.
- **Chosen CM.** The lowest such m.
- **Arbitration.**
  - Requesters are flattened as idx = d*NN + v.
  - A round-robin arbiter selects one winner among allocatable requesters per cycle.
  - The pointer moves to winner+1, modulo 5*NN.
  - The pointer does not move when there is no winner.
- **Grant edge.** On a winner, at the next edge:
  - `gnt`[d][v] ← 1 and `gcm`[d][v] ← m;
  - `imbusy[d][m]` ← 1 and `ombusy[rdir][m]` ← 1;
  - `imcfg[d][m][v]` ← 1;
  - the cfg bit for source d of output rdir in CM m ← 1.
- **Release.** `rel` on a granted (d,v) clears every item above at the next edge. `rel` on an ungranted (d,v) is ignored.
- **Illegal request.** An illegal request with `gnt` low pulses `err` for one cycle and is never granted. It re-pulses every 8 cycles while it is held.
- **Request timing.**
  - `req` dropping before `gnt` withdraws the request.
  - `req` held after `gnt` is ignored until `rel`.
  - `rdir` is sampled only in the winning cycle.
- **Resource invariants.** Each CM input and each CM output carries at most one circuit. The cfg outputs are one-hot or zero per CM output.

## Timing
- **Reset.** All outputs, busy vectors and the arbiter pointer reset to 0. Reset mid-operation drops every circuit within one edge.
- **Latency.** `req` sampled high at edge t gives `gnt` high after edge t+1, with the cfg outputs updated on the same edge.
- **Release latency.** `rel` at edge t makes `gnt` and the cfg bits 0 after t+1. The freed resources are grantable in the decision of cycle t+1, so `gnt` rises after t+2.
- **Release and request in the same cycle.** `rel` and `req` for the same (d,v) in one cycle: the release happens. The new grant comes no earlier than one cycle later, so `gnt` is low for at least one cycle.
- **Throughput.** One grant per cycle. Any number of releases per cycle.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package `clos_pkg` holds:
  - the direction enum (S, W, N, E, L = 0..4);
  - the `legal_turn(d, o)` function;
  - the `cfg_bit(d, o)` mapping function implementing the turn table.
- Sub-module `rr_arb #(N)`: round-robin arbiter with a one-hot grant and a registered pointer; instantiated with N = 5*NN.
- Top level contains:
  - the allocatable mask;
  - the lowest-free-CM priority encoder;
  - the busy registers and cfg registers.

## Test plan
All scenarios use MN = NN = 2.
- **Reset.** Drive random inputs with `rst_n` low for 2 cycles → all outputs 0.
- **Single grant.** L/vc0 requests S at t0 → after t1: `gnt[4][0]`=1, `gcm`=0, `imcfg[4][0][0]`=1, `scfg[0]`=2'b10.
- **Blocked, then granted after release.**
  - Add L/vc1 → S: granted CM1, `scfg[1]`=2'b10.
  - Add N/vc0 → S: stays pending, `gnt` 0.
  - `rel` L/vc0 at t → N/vc0 `gnt` after t+2, `scfg[0]`=2'b01.
- **Illegal turns.** W/vc0 → S, and S/vc1 → S → `err` pulse, no `gnt`, cfg unchanged.
- **Fairness.** E/vc0 and S/vc0 both hold requests to L with one free L output; each releases immediately on grant → grants alternate 1:1 over 20 grants.
- **Reset and release corners.**
  - `rst_n` low while 4 circuits are up → all cleared after 1 edge.
  - `rel` and `req` on the same (d,v) → `gnt` low for ≥1 cycle.

Source files
------------

// File: rtl/clos_pkg.sv
// Shared direction encoding and XY turn table for the data Clos allocator.
package clos_pkg;

  typedef enum logic [2:0] {D_S = 3'd0, D_W = 3'd1, D_N = 3'd2, D_E = 3'd3, D_L = 3'd4} dir_e;

  localparam int NDIR = 5;

  function automatic logic legal_turn(logic [2:0] d, logic [2:0] o);
    logic ok;
    case (o)
      D_S:     ok = (d == D_N) || (d == D_L);
      D_N:     ok = (d == D_S) || (d == D_L);
      D_W:     ok = (d == D_S) || (d == D_N) || (d == D_E) || (d == D_L);
      D_E:     ok = (d == D_S) || (d == D_W) || (d == D_N) || (d == D_L);
      D_L:     ok = (d < D_L);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Position of source d inside the cfg vector of output o; only meaningful for legal turns.
  function automatic logic [1:0] cfg_bit(logic [2:0] d, logic [2:0] o);
    logic [1:0] b;
    case (o)
      D_S, D_N: b = (d == D_L) ? 2'd1 : 2'd0;
      D_W: begin
        case (d)
          D_S:     b = 2'd0;
          D_N:     b = 2'd1;
          D_E:     b = 2'd2;
          default: b = 2'd3;
        endcase
      end
      D_E: begin
        case (d)
          D_S:     b = 2'd0;
          D_W:     b = 2'd1;
          D_N:     b = 2'd2;
          default: b = 2'd3;
        endcase
      end
      default: b = d[1:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant, pointer advances past the winner.
module rr_arb #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW:0]   idx;
  logic          any;

  // Scan from the highest offset down so the closest requester at/after ptr wins.
  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (req[idx[PW-1:0]]) begin
        win = idx[PW-1:0];
        any = 1'b1;
      end
    end
    if (any) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   ptr <= '0;
    else if (any) ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
  end

endmodule

// File: rtl/clos_alloc.sv
// Centre-module allocator for the data Clos network: grants one circuit per cycle and drives all switch configs.
module clos_alloc
  import clos_pkg::*;
#(
  parameter int MN = 2,
  parameter int NN = 2,
  parameter int MW = (MN > 1) ? $clog2(MN) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [4:0][NN-1:0]                 req,
  input  logic [4:0][NN-1:0][2:0]            rdir,
  input  logic [4:0][NN-1:0]                 rel,
  output logic [4:0][NN-1:0]                 gnt,
  output logic [4:0][NN-1:0][MW-1:0]         gcm,
  output logic                               err,
  output logic [4:0][MN-1:0][NN-1:0]         imcfg,
  output logic [MN-1:0][1:0]                 scfg,
  output logic [MN-1:0][1:0]                 ncfg,
  output logic [MN-1:0][3:0]                 wcfg,
  output logic [MN-1:0][3:0]                 ecfg,
  output logic [MN-1:0][3:0]                 lcfg
);
  localparam int NR = NDIR * NN;

  logic [NDIR-1:0][MN-1:0]         imbusy, ombusy, imb_n, omb_n;
  logic [NDIR-1:0][MN-1:0][3:0]    ocfg, ocfg_n;
  logic [NDIR-1:0][NN-1:0][2:0]    odir, odir_n;
  logic [NDIR-1:0][NN-1:0][2:0]    ecnt, ecnt_n;
  logic [NDIR-1:0][NN-1:0][MW-1:0] csel, gcm_n;
  logic [NDIR-1:0][MN-1:0][NN-1:0] imcfg_n;
  logic [NDIR-1:0][NN-1:0]         legal, gnt_n;
  logic [NR-1:0]                   amask, agnt;
  logic                            err_n;

  // Allocatable mask plus lowest-free-CM encoder per requester.
  always_comb begin
    legal = '0;
    csel  = '0;
    amask = '0;
    for (int d = 0; d < NDIR; d++) begin
      for (int v = 0; v < NN; v++) begin
        legal[d][v] = legal_turn(3'(d), rdir[d][v]);
        if (legal[d][v]) begin
          for (int m = MN - 1; m >= 0; m--) begin
            if (!imbusy[d][m] && !ombusy[rdir[d][v]][m]) begin
              csel[d][v]        = MW'(m);
              amask[d*NN + v]   = req[d][v] && !gnt[d][v];
            end
          end
        end
      end
    end
  end

  rr_arb #(.N(NR)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (amask),
    .gnt   (agnt)
  );

  // Releases are applied before the grant; a winner never uses a resource freed this cycle.
  always_comb begin
    gnt_n   = gnt;
    gcm_n   = gcm;
    odir_n  = odir;
    imb_n   = imbusy;
    omb_n   = ombusy;
    imcfg_n = imcfg;
    ocfg_n  = ocfg;
    for (int d = 0; d < NDIR; d++) begin
      for (int v = 0; v < NN; v++) begin
        if (rel[d][v] && gnt[d][v]) begin
          gnt_n[d][v]                                                    = 1'b0;
          gcm_n[d][v]                                                    = '0;
          imb_n[d][gcm[d][v]]                                            = 1'b0;
          omb_n[odir[d][v]][gcm[d][v]]                                   = 1'b0;
          imcfg_n[d][gcm[d][v]][v]                                       = 1'b0;
          ocfg_n[odir[d][v]][gcm[d][v]][cfg_bit(3'(d), odir[d][v])]      = 1'b0;
        end
      end
    end
    for (int d = 0; d < NDIR; d++) begin
      for (int v = 0; v < NN; v++) begin
        if (agnt[d*NN + v]) begin
          gnt_n[d][v]                                                    = 1'b1;
          gcm_n[d][v]                                                    = csel[d][v];
          odir_n[d][v]                                                   = rdir[d][v];
          imb_n[d][csel[d][v]]                                           = 1'b1;
          omb_n[rdir[d][v]][csel[d][v]]                                  = 1'b1;
          imcfg_n[d][csel[d][v]][v]                                      = 1'b1;
          ocfg_n[rdir[d][v]][csel[d][v]][cfg_bit(3'(d), rdir[d][v])]     = 1'b1;
        end
      end
    end
  end

  // A held illegal request re-reports every 8 cycles.
  always_comb begin
    err_n  = 1'b0;
    ecnt_n = ecnt;
    for (int d = 0; d < NDIR; d++) begin
      for (int v = 0; v < NN; v++) begin
        if (req[d][v] && !gnt[d][v] && !legal[d][v]) begin
          if (ecnt[d][v] == 3'd0) err_n = 1'b1;
          ecnt_n[d][v] = ecnt[d][v] + 3'd1;
        end else begin
          ecnt_n[d][v] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt    <= '0;
      gcm    <= '0;
      odir   <= '0;
      imbusy <= '0;
      ombusy <= '0;
      imcfg  <= '0;
      ocfg   <= '0;
      ecnt   <= '0;
      err    <= 1'b0;
    end else begin
      gnt    <= gnt_n;
      gcm    <= gcm_n;
      odir   <= odir_n;
      imbusy <= imb_n;
      ombusy <= omb_n;
      imcfg  <= imcfg_n;
      ocfg   <= ocfg_n;
      ecnt   <= ecnt_n;
      err    <= err_n;
    end
  end

  always_comb begin
    for (int m = 0; m < MN; m++) begin
      scfg[m] = ocfg[D_S][m][1:0];
      ncfg[m] = ocfg[D_N][m][1:0];
      wcfg[m] = ocfg[D_W][m];
      ecfg[m] = ocfg[D_E][m];
      lcfg[m] = ocfg[D_L][m];
    end
  end

  // S and N outputs only have two sources; their upper cfg bits stay zero.
  logic unused_hi;
  assign unused_hi = |{ocfg[D_S], ocfg[D_N]};

endmodule
